// File: rtl/muldiv_unit.sv
// Iterative 32-bit signed multiply / divide / modulo unit for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up after 32 iterations.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_zero
);

    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        neg32 = (~x) + 32'd1;
    endfunction

    // Magnitude of a two's complement word; 32'h80000000 maps to itself as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        abs32 = x[31] ? neg32(x) : x;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  op_r, op_s;
    logic        sign_r, sign_s;
    logic [31:0] a_mag_r, a_mag_s;
    logic [31:0] b_mag_r, b_mag_s;
    logic [31:0] acc_r, acc_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [31:0] result_r, result_s;
    logic        div_zero_r, div_zero_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    logic        legal_s;
    logic        accept_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;

    // Next-state, datapath iteration and output staging.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        sign_s      = sign_r;
        a_mag_s     = a_mag_r;
        b_mag_s     = b_mag_r;
        acc_s       = acc_r;
        cnt_s       = cnt_r;
        result_s    = result_r;
        div_zero_s  = div_zero_r;
        legal_s     = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
        accept_s    = start && legal_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        // Partial remainder shifted left with the next dividend bit brought in.
        rem_shift_s = {acc_r, a_mag_r[31]};
        diff_s      = rem_shift_s - {1'b0, b_mag_r};

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_s    = op;
                    a_mag_s = abs32(A);
                    b_mag_s = abs32(B);
                    acc_s   = 32'd0;
                    cnt_s   = 5'd0;
                    sign_s  = (op == OP_MOD) ? A[31] : (A[31] ^ B[31]);
                    if ((op != OP_MUL) && (B == 32'd0)) begin
                        state_s    = ST_DONE;
                        result_s   = (op == OP_DIV) ? 32'hFFFF_FFFF : A;
                        div_zero_s = 1'b1;
                    end else begin
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (op_r == OP_MUL) begin
                    if (b_mag_r[0]) begin
                        acc_s = acc_r + a_mag_r;
                    end else begin
                        acc_s = acc_r;
                    end
                    a_mag_s = {a_mag_r[30:0], 1'b0};
                    b_mag_s = {1'b0, b_mag_r[31:1]};
                end else begin
                    if (!diff_s[32]) begin
                        acc_s   = diff_s[31:0];
                        a_mag_s = {a_mag_r[30:0], 1'b1};
                    end else begin
                        acc_s   = rem_shift_s[31:0];
                        a_mag_s = {a_mag_r[30:0], 1'b0};
                    end
                end
                cnt_s = cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                case (op_r)
                    OP_MUL:  result_s = sign_r ? neg32(acc_r) : acc_r;
                    OP_DIV:  result_s = sign_r ? neg32(a_mag_r) : a_mag_r;
                    OP_MOD:  result_s = sign_r ? neg32(acc_r) : acc_r;
                    default: result_s = 32'd0;
                endcase
                div_zero_s = 1'b0;
                state_s    = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_CALC) || (state_s == ST_FIX);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= 4'd0;
            sign_r     <= 1'b0;
            a_mag_r    <= 32'd0;
            b_mag_r    <= 32'd0;
            acc_r      <= 32'd0;
            cnt_r      <= 5'd0;
            result_r   <= 32'd0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            sign_r     <= sign_s;
            a_mag_r    <= a_mag_s;
            b_mag_r    <= b_mag_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            result_r   <= result_s;
            div_zero_r <= div_zero_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, div-by-zero,
// ignored/back-to-back starts, illegal op and asynchronous reset.
module tb_muldiv_unit;

    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;
    int n;
    int bc;
    int dseen;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle from a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done (bounded) and how many sampled cycles had busy high.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 7 * -6
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFA);
        wait_done(n, bc);
        chk("mul_latency", n, 32'd33);
        chk("mul_busy_cycles", bc, 32'd33);
        chk("mul_result", result, 32'hFFFF_FFD6);
        chk("mul_dz", {31'd0, div_zero}, 32'd0);

        // Start while in DONE: accepted with no idle gap.
        issue(OP_DIV, 32'hFFFF_FFEF, 32'd5);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        chk("b2b_result_hold", result, 32'hFFFF_FFD6);
        wait_done(n, bc);
        chk("div_latency", n, 32'd33);
        chk("div_busy_cycles", bc, 32'd33);
        chk("div_result", result, 32'hFFFF_FFFD);

        issue(OP_MOD, 32'hFFFF_FFEF, 32'd5);
        wait_done(n, bc);
        chk("mod_latency", n, 32'd33);
        chk("mod_result", result, 32'hFFFF_FFFE);

        // Start during CALC is ignored; 0x12345 * 0x10000 truncates to 0x23450000.
        issue(OP_MUL, 32'h0001_2345, 32'h0001_0000);
        @(negedge clk);
        @(negedge clk);
        op    = OP_DIV;
        A     = 32'd1;
        B     = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        chk("ignored_start_latency", n, 32'd30);
        chk("ignored_start_result", result, 32'h2345_0000);
        @(negedge clk);
        chk("idle_done_low", {31'd0, done}, 32'd0);
        chk("idle_busy_low", {31'd0, busy}, 32'd0);
        chk("idle_result_hold", result, 32'h2345_0000);

        // Divide by zero
        issue(OP_DIV, 32'd9, 32'd0);
        wait_done(n, bc);
        chk("dz_div_latency", n, 32'd0);
        chk("dz_div_busy", bc, 32'd0);
        chk("dz_div_result", result, 32'hFFFF_FFFF);
        chk("dz_div_flag", {31'd0, div_zero}, 32'd1);
        @(negedge clk);
        chk("dz_done_one_cycle", {31'd0, done}, 32'd0);
        chk("dz_result_hold", result, 32'hFFFF_FFFF);
        chk("dz_flag_hold", {31'd0, div_zero}, 32'd1);
        issue(OP_MOD, 32'd9, 32'd0);
        wait_done(n, bc);
        chk("dz_mod_latency", n, 32'd0);
        chk("dz_mod_result", result, 32'd9);
        chk("dz_mod_flag", {31'd0, div_zero}, 32'd1);

        // div_zero holds until the next operation completes.
        issue(OP_MUL, 32'hFFFF_FFFF, 32'h8000_0000);
        chk("dz_hold_in_calc", {31'd0, div_zero}, 32'd1);
        wait_done(n, bc);
        chk("mul_min_result", result, 32'h8000_0000);
        chk("mul_min_dz", {31'd0, div_zero}, 32'd0);

        // Overflow: 0x80000000 / -1
        issue(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("ovf_mod_result", result, 32'd0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("ovf_div_result", result, 32'h8000_0000);
        chk("ovf_div_dz", {31'd0, div_zero}, 32'd0);

        // Illegal op is ignored.
        @(negedge clk);
        issue(4'b0001, 32'd5, 32'd5);
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("illegal_busy_later", {31'd0, busy}, 32'd0);
        chk("illegal_result_hold", result, 32'h8000_0000);

        // Asynchronous reset in the middle of a divide.
        issue(OP_DIV, 32'hFFFF_FFEF, 32'd5);
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("rst_no_done", dseen, 32'd0);
        issue(OP_MUL, 32'd3, 32'd4);
        wait_done(n, bc);
        chk("post_rst_latency", n, 32'd33);
        chk("post_rst_result", result, 32'd12);
        chk("post_rst_dz", {31'd0, div_zero}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; clock `clk`, reset `rst`.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: start  input  1  issue strobe from EX stage; sampled on rising clk.
REQ-005 Port: op  input  4  integer ALU opcode: 4'b0011 mul, 4'b0100 div, 4'b0101 mod; other codes are illegal.
REQ-006 Port: A  input  32  source 1, two's complement (dividend / multiplicand).
REQ-007 Port: B  input  32  source 2, two's complement (divisor / multiplier).
REQ-008 Port: busy  output  1  high while an operation is in flight; feeds the EX BUSY/stall.
REQ-009 Port: done  output  1  one-cycle pulse, result valid.
REQ-010 Port: result  output  32  product low word, quotient, or remainder.
REQ-011 Port: div_zero  output  1  qualifies done; divisor was zero.

Function
REQ-012 States SHALL be IDLE, CALC, FIX and DONE, held in a registered state variable.
REQ-013 Accept: start=1 with a legal op in IDLE or DONE at edge E0 SHALL latch op and the operand magnitudes, record the result sign, clear the iteration counter, and enter CALC.
REQ-014 A start in CALC or FIX SHALL be ignored: no operand or state change.
REQ-015 A start with an illegal op SHALL be ignored in every state.
REQ-016 CALC SHALL perform one iteration per edge for 32 edges (E1..E32), using a 5-bit counter that wraps 31->0 on E32; E32 SHALL move to FIX.
REQ-017 mul SHALL use shift-add on magnitudes; result = low 32 bits of the signed product, sign = A[31]^B[31]; overflow is silently truncated.
REQ-018 div/mod SHALL use restoring division on magnitudes.
REQ-019 The quotient SHALL truncate toward zero, with sign A[31]^B[31].
REQ-020 The remainder SHALL carry the sign of A.
REQ-021 FIX SHALL apply the sign correction; E33 SHALL register result and move to DONE.
REQ-022 busy SHALL be 1 in cycles following E0..E32 (33 cycles) and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 exactly in DONE, which lasts one cycle; DONE SHALL return to IDLE unless a new start is accepted.
REQ-024 result and div_zero SHALL hold their values until the next accepted start completes.
REQ-025 Divide by zero (B=0, op div/mod) SHALL skip CALC and FIX: E0 SHALL enter DONE with div_zero=1, result=32'hFFFFFFFF for div and result=A for mod, and busy SHALL stay 0.
REQ-026 Overflow case A=32'h80000000, B=32'hFFFFFFFF, div SHALL give 32'h80000000; mod SHALL give 0.
REQ-027 div_zero SHALL be 0 for mul and for a nonzero divisor.
REQ-028 Outputs SHALL be driven from registers only, with no combinational path from inputs.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, result=0, div_zero=0 and counter=0, regardless of clk.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 mul: A=7, B=-6, start at E0 -> busy for 33 cycles, done in cycle 33, result=32'hFFFFFFD6, div_zero=0.
REQ-032 div/mod: A=-17, B=5 -> div result=32'hFFFFFFFD (-3), mod result=32'hFFFFFFFE (-2), each done 33 cycles after start.
REQ-033 Divide by zero: A=9, B=0, op div -> done in cycle after E0, busy never high, result=32'hFFFFFFFF, div_zero=1; op mod -> result=9.
REQ-034 Back-to-back and ignored starts: start during CALC with A=1, B=1 ignored (first result intact); start asserted in DONE is accepted, busy rises next cycle, no idle gap.
REQ-035 Reset mid-operation: rst pulse at cycle 10 of a div -> outputs zero asynchronously, no done; a following mul 3*4 gives result=12.
REQ-036 Overflow and illegal op: 32'h80000000 / -1 -> 32'h80000000; op=4'b0001 with start -> no state change, busy stays 0.
